// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the RMII Ethernet packer/unpacker pair.
//   - eth_state_e : receive state machine encoding
//   - field sizes in dibits (address, length, FCS, default payload)
//   - BCAST_DIBIT : every dibit of the broadcast destination address
//   - mac_dibit() : k-th on-wire dibit of a 48-bit MAC address
package eth_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DEST_ADDR,
    ST_SRC_ADDR,
    ST_LENGTH,
    ST_DATA,
    ST_FCS,
    ST_DROP
  } eth_state_e;

  localparam int ADDR_DIBITS         = 24;
  localparam int LEN_DIBITS          = 8;
  localparam int FCS_DIBITS          = 16;
  localparam int DEFAULT_DATA_DIBITS = 5120;

  localparam logic [1:0] BCAST_DIBIT = 2'b11;
  localparam logic [1:0] PRE_DIBIT   = 2'b01;
  localparam logic [1:0] SFD_DIBIT   = 2'b11;

  // Bytes go out most-significant byte first, each byte LSB first, two bits
  // per RMII clock with the earlier bit on rxd[0].
  function automatic logic [1:0] mac_dibit(input logic [47:0] mac,
                                           input logic [4:0]  k);
    logic [7:0] byte_v;
    int         byte_i;
    int         pair_i;
    byte_i = int'(k[4:2]);
    pair_i = int'(k[1:0]);
    byte_v = mac[8*(5-byte_i) +: 8];
    return byte_v[2*pair_i +: 2];
  endfunction

endpackage

// File: rtl/crc32.sv
// crc32: Ethernet CRC-32 over an RMII dibit stream, two bits per clock.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (state to all ones)
//   clr    : synchronous restart of the CRC (state to all ones)
//   axiiv  : axiid is a dibit belonging to the checked region
//   axiid  : dibit, axiid[0] is the earlier bit on the wire
//   axiod  : complemented CRC register, MSB-first (non-reflected) form
// The register runs the MSB-first form of polynomial 0x04C11DB7; its
// complement is therefore the bit-reverse of the conventional FCS value.
module crc32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic [31:0] axiod
);

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] state_q;
  logic [31:0] state_d;

  function automatic logic [31:0] crc_bit(input logic [31:0] s, input logic b);
    return {s[30:0], 1'b0} ^ (((s[31] ^ b) == 1'b1) ? POLY : 32'h0);
  endfunction

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = '1;
    end else if (axiiv) begin
      state_d = crc_bit(crc_bit(state_q, axiid[0]), axiid[1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '1;
    end else begin
      state_q <= state_d;
    end
  end

  assign axiod = ~state_q;

endmodule

// File: rtl/eth_unpacker.sv
// eth_unpacker: RMII receive path. Hunts preamble/SFD, walks destination,
// source and length fields, streams a fixed-length payload as a dibit
// stream and checks the FCS with crc32.
//   Parameters: DATA_DIBITS (payload dibits), PREAMBLE_MIN (01 dibits needed
//               before SFD), MY_MAC (unicast address when filtering)
//   clk, rst_n          : 50 MHz RMII clock, asynchronous active-low reset
//   phy_crsdv, phy_rxd  : RMII carrier-sense/data-valid and receive dibit
//   axiov, axiod        : payload dibit valid / dibit (registered, 1 cycle)
//   done                : one-cycle pulse, frame fully received
//   crc_ok              : FCS matched, meaningful while done=1
//   len_field           : raw length dibits, first dibit in [15:14]
//   kill                : one-cycle pulse, frame aborted
// Build option: define ETH_UNPACKER_ADDR_FILTER_EN to accept only broadcast
// or MY_MAC destinations; otherwise no address comparator is built.
module eth_unpacker
  import eth_pkg::*;
#(
  parameter int          DATA_DIBITS  = DEFAULT_DATA_DIBITS,
  parameter int          PREAMBLE_MIN = 8,
  parameter logic [47:0] MY_MAC       = 48'h69695A065491
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phy_crsdv,
  input  logic [1:0]  phy_rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        done,
  output logic        crc_ok,
  output logic [15:0] len_field,
  output logic        kill
);

  localparam logic [12:0] ADDR_LAST = 13'(ADDR_DIBITS - 1);
  localparam logic [12:0] LEN_LAST  = 13'(LEN_DIBITS - 1);
  localparam logic [12:0] DATA_LAST = 13'(DATA_DIBITS - 1);
  localparam logic [12:0] FCS_LAST  = 13'(FCS_DIBITS - 1);
  localparam logic [4:0]  PRE_MIN   = 5'(PREAMBLE_MIN);

  eth_state_e  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [4:0]  pre_cnt_q, pre_cnt_d;
  logic [31:0] fcs_q, fcs_d;
  logic [15:0] len_q, len_d;
  logic        axiov_q, axiov_d;
  logic [1:0]  axiod_q, axiod_d;
  logic        done_q, done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        kill_q, kill_d;

  logic        crc_clr;
  logic        crc_en;
  logic [31:0] crc_out;
  logic        addr_ok;

`ifdef ETH_UNPACKER_ADDR_FILTER_EN
  logic ucast_q, ucast_d;
  logic bcast_q, bcast_d;
`endif

  crc32 crc32 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .axiiv (crc_en),
    .axiid (phy_rxd),
    .axiod (crc_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;           // counter clears unless a state extends itself
    pre_cnt_d = pre_cnt_q;
    fcs_d     = fcs_q;
    len_d     = len_q;
    axiov_d   = 1'b0;
    axiod_d   = axiod_q;
    done_d    = 1'b0;
    crc_ok_d  = 1'b0;
    kill_d    = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    addr_ok   = 1'b1;
`ifdef ETH_UNPACKER_ADDR_FILTER_EN
    ucast_d   = ucast_q;
    bcast_d   = bcast_q;
`endif

    unique case (state_q)
      ST_WAIT_IDLE: begin
        // Trailing dibits and frames already in flight at reset release are
        // ignored until the line goes quiet.
        if (!phy_crsdv) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (phy_crsdv) begin
          state_d   = ST_PREAMBLE;
          pre_cnt_d = (phy_rxd == PRE_DIBIT) ? 5'd1 : 5'd0;
        end
      end

      ST_PREAMBLE: begin
        if (!phy_crsdv) begin
          state_d = ST_IDLE;
        end else if (phy_rxd == PRE_DIBIT) begin
          pre_cnt_d = (pre_cnt_q == 5'd31) ? pre_cnt_q : pre_cnt_q + 5'd1;
        end else if (phy_rxd == SFD_DIBIT && pre_cnt_q >= PRE_MIN) begin
          state_d = ST_DEST_ADDR;
          crc_clr = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DEST_ADDR: begin
        if (!phy_crsdv) begin
          state_d = ST_IDLE;
          kill_d  = 1'b1;
        end else begin
          crc_en = 1'b1;
`ifdef ETH_UNPACKER_ADDR_FILTER_EN
          // Running match flags; the first dibit starts both afresh.
          ucast_d = ((cnt_q == '0) ? 1'b1 : ucast_q) &
                    (phy_rxd == mac_dibit(MY_MAC, cnt_q[4:0]));
          bcast_d = ((cnt_q == '0) ? 1'b1 : bcast_q) &
                    (phy_rxd == BCAST_DIBIT);
          addr_ok = ucast_d | bcast_d;
`endif
          if (cnt_q == ADDR_LAST) begin
            if (addr_ok) begin
              state_d = ST_SRC_ADDR;
            end else begin
              state_d = ST_DROP;
              kill_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
      end

      ST_SRC_ADDR: begin
        if (!phy_crsdv) begin
          state_d = ST_IDLE;
          kill_d  = 1'b1;
        end else begin
          crc_en = 1'b1;
          if (cnt_q == ADDR_LAST) state_d = ST_LENGTH;
          else                    cnt_d   = cnt_q + 13'd1;
        end
      end

      ST_LENGTH: begin
        if (!phy_crsdv) begin
          state_d = ST_IDLE;
          kill_d  = 1'b1;
        end else begin
          crc_en = 1'b1;
          len_d  = {len_q[13:0], phy_rxd};
          if (cnt_q == LEN_LAST) state_d = ST_DATA;
          else                   cnt_d   = cnt_q + 13'd1;
        end
      end

      ST_DATA: begin
        if (!phy_crsdv) begin
          state_d = ST_IDLE;
          kill_d  = 1'b1;
        end else begin
          crc_en  = 1'b1;
          axiov_d = 1'b1;
          axiod_d = phy_rxd;
          if (cnt_q == DATA_LAST) state_d = ST_FCS;
          else                    cnt_d   = cnt_q + 13'd1;
        end
      end

      ST_FCS: begin
        // The PHY may drop carrier together with the final FCS dibit; that
        // dibit is still valid and completes the frame.
        if (!phy_crsdv && cnt_q != FCS_LAST) begin
          state_d = ST_IDLE;
          kill_d  = 1'b1;
        end else begin
          // Shifting left with rxd[0] ahead of rxd[1] lands the first wire
          // bit in fcs[31], matching the bit order of crc_out.
          fcs_d = {fcs_q[29:0], phy_rxd[0], phy_rxd[1]};
          if (cnt_q == FCS_LAST) begin
            state_d  = ST_WAIT_IDLE;
            done_d   = 1'b1;
            crc_ok_d = (fcs_d == crc_out);
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
      end

      ST_DROP: begin
        if (!phy_crsdv) state_d = ST_IDLE;
      end

      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_IDLE;
      cnt_q     <= '0;
      pre_cnt_q <= '0;
      fcs_q     <= '0;
      len_q     <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= '0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      kill_q    <= 1'b0;
`ifdef ETH_UNPACKER_ADDR_FILTER_EN
      ucast_q   <= 1'b0;
      bcast_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_cnt_q <= pre_cnt_d;
      fcs_q     <= fcs_d;
      len_q     <= len_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      kill_q    <= kill_d;
`ifdef ETH_UNPACKER_ADDR_FILTER_EN
      ucast_q   <= ucast_d;
      bcast_q   <= bcast_d;
`endif
    end
  end

  assign axiov     = axiov_q;
  assign axiod     = axiod_q;
  assign done      = done_q;
  assign crc_ok    = crc_ok_q;
  assign len_field = len_q;
  assign kill      = kill_q;

endmodule

// File: tb/tb_eth_unpacker.sv
// tb_eth_unpacker: randomized frame stimulus for eth_unpacker. Frames are
// built byte-wise with a bit-serial reflected CRC-32; expected payload,
// axiov run lengths and done/kill events are queued when a frame is issued
// and a monitor compares them against whatever the DUT emits.
module tb_eth_unpacker;

  localparam int          DATA_DIBITS  = 5120;
  localparam int          PREAMBLE_MIN = 8;
  localparam logic [47:0] MY_MAC       = 48'h69695A065491;

  typedef struct packed {
    logic        is_done;
    logic        crc_ok;
    logic [15:0] len;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        phy_crsdv = 1'b0;
  logic [1:0]  phy_rxd = 2'b00;
  logic        axiov;
  logic [1:0]  axiod;
  logic        done;
  logic        crc_ok;
  logic [15:0] len_field;
  logic        kill;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_data[$];
  int         exp_runs[$];
  evt_t       exp_evt[$];

  always #10 clk = ~clk;

  eth_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phy_crsdv (phy_crsdv),
    .phy_rxd   (phy_rxd),
    .axiov     (axiov),
    .axiod     (axiod),
    .done      (done),
    .crc_ok    (crc_ok),
    .len_field (len_field),
    .kill      (kill)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference CRC: bit-serial reflected CRC-32, earlier wire bit first.
  function automatic logic [31:0] ref_crc(input logic [1:0] q[$]);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 2; b++) begin
        if ((r[0] ^ q[i][b]) == 1'b1) r = (r >> 1) ^ 32'hEDB8_8320;
        else                          r = r >> 1;
      end
    end
    return ~r;
  endfunction

  // Monitor: sampled 1 time unit after each rising edge.
  int run_len = 0;
  always @(posedge clk) begin
    #1;
    if (axiov === 1'b1) begin
      run_len++;
      chk("axiov_expected", 32'(exp_data.size() != 0), 32'd1);
      if (exp_data.size() != 0) chk("axiod", 32'(axiod), 32'(exp_data.pop_front()));
    end else if (run_len > 0) begin
      chk("run_expected", 32'(exp_runs.size() != 0), 32'd1);
      if (exp_runs.size() != 0) chk("axiov_run_len", 32'(run_len), 32'(exp_runs.pop_front()));
      run_len = 0;
    end
    if (done === 1'b1 || kill === 1'b1) begin
      chk("done_kill_exclusive", 32'(done & kill), 32'd0);
      chk("event_expected", 32'(exp_evt.size() != 0), 32'd1);
      if (exp_evt.size() != 0) begin
        evt_t e;
        e = exp_evt.pop_front();
        chk("event_is_done", 32'(done), 32'(e.is_done));
        if (e.is_done) begin
          chk("crc_ok", 32'(crc_ok), 32'(e.crc_ok));
          chk("len_field", 32'(len_field), 32'(e.len));
        end
      end
    end
  end

  task automatic drive(input logic c, input logic [1:0] d);
    @(negedge clk);
    phy_crsdv = c;
    phy_rxd   = d;
  endtask

  task automatic gap(input int n);
    repeat (n) drive(1'b0, 2'($urandom));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_axiov"},     32'(axiov),     32'd0);
    chk({tag, "_axiod"},     32'(axiod),     32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_crc_ok"},    32'(crc_ok),    32'd0);
    chk({tag, "_kill"},      32'(kill),      32'd0);
    chk({tag, "_len_field"}, 32'(len_field), 32'd0);
  endtask

  // Build one frame, queue what the DUT should produce, then drive it.
  // corrupt_at/cut_at/rst_at are payload dibit indices, negative = unused;
  // cut_at beyond the payload reaches into the FCS.
  task automatic run_frame(input int npre, input logic [47:0] dest,
                           input int corrupt_at, input int cut_at, input int rst_at,
                           input bit last_low, input bit counting, input logic [15:0] len);
    logic [1:0]  body[$];
    logic [1:0]  fr[$];
    logic [47:0] src;
    logic [31:0] crc;
    logic [7:0]  b;
    bit          pre_ok, addr_ok;
    int          hdr, pay0, stop_idx, npay;

    src = {16'($urandom), 32'($urandom)};
    for (int i = 0; i < 6; i++) begin
      b = dest[47-8*i -: 8];
      for (int m = 0; m < 4; m++) body.push_back(b[2*m +: 2]);
    end
    for (int i = 0; i < 6; i++) begin
      b = src[47-8*i -: 8];
      for (int m = 0; m < 4; m++) body.push_back(b[2*m +: 2]);
    end
    for (int i = 0; i < 8; i++) body.push_back(len[15-2*i -: 2]);
    for (int i = 0; i < DATA_DIBITS; i++)
      body.push_back(counting ? 2'(i) : 2'($urandom));
    crc = ref_crc(body);
    if (corrupt_at >= 0) body[56+corrupt_at] = body[56+corrupt_at] ^ 2'b10;

    for (int i = 0; i < npre; i++) fr.push_back(2'b01);
    fr.push_back(2'b11);
    hdr = fr.size();
    foreach (body[i]) fr.push_back(body[i]);
    for (int k = 0; k < 16; k++) fr.push_back({crc[2*k+1], crc[2*k]});
    pay0 = hdr + 56;

    pre_ok = (npre >= PREAMBLE_MIN);
`ifdef ETH_UNPACKER_ADDR_FILTER_EN
    addr_ok = (dest == 48'hFFFF_FFFF_FFFF) || (dest == MY_MAC);
`else
    addr_ok = 1'b1;
`endif
    stop_idx = fr.size();
    if (!pre_ok) begin
      stop_idx = hdr + 40;
    end else if (!addr_ok) begin
      exp_evt.push_back('{is_done: 1'b0, crc_ok: 1'b0, len: 16'h0});
      stop_idx = hdr + 32;
    end else begin
      npay = DATA_DIBITS;
      if (cut_at >= 0 && cut_at < npay) npay = cut_at;
      if (rst_at >= 0) npay = rst_at;
      for (int i = 0; i < npay; i++) exp_data.push_back(body[56+i]);
      if (npay > 0) exp_runs.push_back(npay);
      if (cut_at >= 0)
        exp_evt.push_back('{is_done: 1'b0, crc_ok: 1'b0, len: 16'h0});
      else if (rst_at < 0)
        exp_evt.push_back('{is_done: 1'b1, crc_ok: (corrupt_at < 0), len: len});
    end

    for (int idx = 0; idx < stop_idx; idx++) begin
      int p;
      p = idx - pay0;
      if (rst_at >= 0 && p == rst_at) begin
        @(negedge clk);
        rst_n     = 1'b0;
        phy_crsdv = 1'b1;
        phy_rxd   = fr[idx];
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      if (cut_at >= 0 && p == cut_at) begin
        drive(1'b0, fr[idx]);
        break;
      end
      drive(!(last_low && idx == fr.size() - 1), fr[idx]);
    end
  endtask

  initial begin
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    gap(3);

    // Loopback-style frame: counting payload, known length.
    run_frame(31, MY_MAC, -1, -1, -1, 1'b0, 1'b1, 16'hABCD);
    gap(3);
    // Corrupted payload dibit, broadcast destination.
    run_frame(28, 48'hFFFF_FFFF_FFFF, int'($urandom_range(0, DATA_DIBITS-1)), -1, -1, 1'b0, 1'b0, 16'($urandom));
    gap(2);
    // Short preamble, then a frame at exactly the minimum preamble.
    run_frame(5, MY_MAC, -1, -1, -1, 1'b0, 1'b0, 16'h1234);
    gap(2);
    run_frame(PREAMBLE_MIN, MY_MAC, -1, -1, -1, 1'b0, 1'b0, 16'($urandom));
    gap(2);
    run_frame(PREAMBLE_MIN - 1, MY_MAC, -1, -1, -1, 1'b0, 1'b0, 16'h0F0F);
    gap(2);
    // Carrier lost at payload dibit 100.
    run_frame(28, MY_MAC, -1, 100, -1, 1'b0, 1'b0, 16'h5555);
    gap(2);
    // Reset pulse at payload dibit 2000 with carrier still up, then a frame.
    run_frame(28, MY_MAC, -1, -1, 2000, 1'b0, 1'b0, 16'h7777);
    gap(2);
    run_frame(28, 48'hFFFF_FFFF_FFFF, -1, -1, -1, 1'b0, 1'b0, 16'($urandom));
    // Carrier falls with the last FCS dibit; shortest legal gap follows.
    gap(2);
    run_frame(40, MY_MAC, -1, -1, -1, 1'b1, 1'b0, 16'($urandom));
    gap(1);
    run_frame(20, MY_MAC, -1, -1, -1, 1'b0, 1'b1, 16'hABCD);
    gap(3);
    // Carrier lost inside the FCS.
    run_frame(28, MY_MAC, -1, DATA_DIBITS + 14, -1, 1'b0, 1'b0, 16'h2468);
    gap(2);
    // Foreign unicast destination: accepted or dropped depending on build.
    run_frame(28, 48'h0123_4567_89AB, -1, -1, -1, 1'b0, 1'b0, 16'h1357);
    gap(2);
    run_frame(int'($urandom_range(8, 31)), MY_MAC, -1, -1, -1, 1'b0, 1'b0, 16'($urandom));

    gap(20);
    chk("payload_drained", 32'(exp_data.size()), 32'd0);
    chk("runs_drained",    32'(exp_runs.size()), 32'd0);
    chk("events_drained",  32'(exp_evt.size()),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_unpacker.md
# eth_unpacker

- Receive-side counterpart of the FPGA1 Ethernet packer: consumes RMII dibits from the PHY and finds preamble/SFD.
- Walks the destination, source and length fields, then streams the fixed-length payload out as an AXI-style dibit stream.
- Checks the 32-bit FCS with the shared `crc32` block.
- Sits between the PHY pins and downstream payload consumers, reporting per-frame status.

## Interface
- `DATA_DIBITS`, 5120, payload length in dibits (fixed frame size)
- `PREAMBLE_MIN`, 8, minimum consecutive `01` dibits before SFD
- `MY_MAC`, 48'h69695A065491, unicast address accepted when filtering
- `clk` in 1: 50 MHz RMII reference clock; all logic on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `phy_crsdv` in 1: RMII carrier-sense/data-valid
- `phy_rxd` in 2: RMII receive dibit
- `axiov` out 1: payload dibit valid
- `axiod` out 2: payload dibit, passed through unmodified
- `done` out 1: one-cycle pulse, frame fully received
- `crc_ok` out 1: FCS matched; valid only while `done`=1
- `len_field` out 16: raw length dibits, first dibit in [15:14]; valid while `done`=1
- `kill` out 1: one-cycle pulse, frame aborted

## Operation
- States:
  - WaitIdle: need `crsdv`=0 before hunting.
  - Idle: on `crsdv`=1 go to Preamble.
  - Preamble: count `01` dibits. An `11` with count ≥ `PREAMBLE_MIN` goes to DestAddr. An `11` with count < `PREAMBLE_MIN`, or any other dibit, goes to Drop.
  - DestAddr: 24 dibits.
  - SrcAddr: 24 dibits.
  - Length: 8 dibits.
  - Data: `DATA_DIBITS` dibits.
  - Fcs: 16 dibits.
  - Drop: wait for `crsdv`=0.
- `crc32` sub-module:
  - Reset at SFD detection.
  - `axiiv`=1 for exactly the DestAddr, SrcAddr, Length and Data dibits; fed `phy_rxd`.
- FCS reassembly: for FCS dibit k (0..15), j=k/4, b=2·(k%4):
  - `rxd[0]` → `fcs[31-8j-b]`
  - `rxd[1]` → `fcs[30-8j-b]`
- Completion:
  - `crc_ok` = (`fcs` == `crc32` output).
  - `done` pulses on the cycle after the 16th FCS dibit is sampled, then state goes to WaitIdle.
  - WaitIdle ignores trailing dibits.
- Abort:
  - `crsdv` low while in DestAddr..Fcs → `kill` pulses for one cycle.
  - No `done` is issued; state goes to Idle.
- Address mismatch (filter enabled only):
  - Decided when the 24th dest dibit is sampled.
  - Go to Drop, `kill` pulses, no payload is ever output.

## Timing
- `axiod`/`axiov` are registered: payload dibit sampled at edge N appears at edge N+1.
- `axiov` is high for exactly `DATA_DIBITS` consecutive cycles with no gaps.
- There is no backpressure.
- Reset values:
  - `axiov`, `done`, `crc_ok`, `kill` = 0.
  - `axiod` = 0, `len_field` = 0.
  - State = WaitIdle.
- Reset mid-frame:
  - All outputs drop immediately (asynchronous).
  - After release the block stays in WaitIdle until `crsdv`=0, so it never locks mid-frame.
- `crsdv` falling on the same cycle as the last FCS dibit: that dibit is still sampled and `done` is issued.
- `done` and `kill` are never asserted together.
- After `done`, a new frame may start as soon as `crsdv` has been sampled low for one cycle.
- Counters:
  - 13-bit dibit counter, cleared at every state transition.
  - Preamble counter saturates at 31.

## Configuration
- `ETH_UNPACKER_ADDR_FILTER_EN`:
  - Defined: accept only frames whose destination is broadcast (all `11` dibits) or `MY_MAC` in on-wire dibit order; drop all others as in Operation.
  - Undefined: all destinations accepted and the comparator is not built.

## Structure
- `eth_pkg` holds:
  - The states enum.
  - `ADDR_DIBITS`=24, `LEN_DIBITS`=8, `FCS_DIBITS`=16, `DEFAULT_DATA_DIBITS`=5120.
  - `BCAST_DIBIT`=2'b11.
- The packer uses the same constants.
- One sub-module: existing `crc32`, instantiated as `crc32`.
- No other hierarchy.

## Test plan
- Packer loopback:
  - Stimulus: packer `phy_txd`/`phy_txen` wired to `phy_rxd`/`phy_crsdv`, counting-pattern payload.
  - Expect: 5120 `axiov` cycles with matching data, then `done`=1, `crc_ok`=1, `len_field`=16'hABCD.
- Corrupted payload:
  - Stimulus: flip one payload dibit.
  - Expect: `done`=1 with `crc_ok`=0; payload still streamed.
- Short preamble:
  - Stimulus: 5×`01` then `11`.
  - Expect: Drop; no `axiov`, no `done`.
  - The next well-formed frame is received correctly.
- Early carrier loss:
  - Stimulus: `crsdv` low at payload dibit 100.
  - Expect: `kill` one-cycle pulse, exactly 100 `axiov` cycles, no `done`.
- Reset mid-frame:
  - Stimulus: `rst_n` pulsed low at payload dibit 2000 with `crsdv` still high.
  - Expect: outputs 0 at once and no output until `crsdv` falls.
  - The following frame gives `done`, `crc_ok`=1.
- Address filter (macro defined):
  - Stimulus: destination 48'h0123456789AB.
  - Expect: `kill` after the dest field and no `axiov`.
  - Broadcast and `MY_MAC` frames are both accepted.
